// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral bus master: command ops, FSM states,
// command record layout and the peripheral address map.
package periph_bus_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_POLL  = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } state_t;

  typedef struct packed {
    op_t         op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mask;
  } cmd_t;

  // Peripheral address map
  localparam logic [31:0] TIMER_CTRL_ADDR  = 32'h4000_0000;
  localparam logic [31:0] TIMER_LOAD_ADDR  = 32'h4000_0004;
  localparam logic [31:0] TIMER_COUNT_ADDR = 32'h4000_0008;
  localparam logic [31:0] LED_ADDR         = 32'h4000_000C;
  localparam logic [31:0] SWITCH_ADDR      = 32'h4000_0010;
  localparam logic [31:0] DIGIT_ADDR       = 32'h4000_0014;
  localparam logic [31:0] UART_TXDATA_ADDR = 32'h4000_0018;
  localparam logic [31:0] UART_RXDATA_ADDR = 32'h4000_001C;
  localparam logic [31:0] UART_STATUS_ADDR = 32'h4000_0020;
  localparam logic [31:0] UART_CTRL_ADDR   = 32'h4000_0024;
  localparam logic [31:0] UART_BAUD_ADDR   = 32'h4000_0028;

  localparam logic [31:0] PERIPH_FIRST_ADDR = TIMER_CTRL_ADDR;
  localparam logic [31:0] PERIPH_LAST_ADDR  = UART_BAUD_ADDR;

  // True when the address falls inside the mapped peripheral window
  function automatic logic is_periph_addr(input logic [31:0] a);
    return (a >= PERIPH_FIRST_ADDR) && (a <= PERIPH_LAST_ADDR);
  endfunction

endpackage

// File: rtl/periph_bus_master_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; head entry is visible
// combinationally on pop_data while not empty.
module cmd_fifo
  import periph_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  cmd_t push_data,
  output logic full,
  input  logic pop,
  output cmd_t pop_data,
  output logic empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cmd_t         mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Extra pointer bit distinguishes full from empty when indices coincide
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; push and pop in the same cycle are both honoured
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/periph_bus_master.sv
// Peripheral bus master: queues read/write/poll commands and executes them
// one at a time on a simple single-cycle strobe bus.
module periph_bus_master
  import periph_bus_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LIMIT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [31:0]        cmd_addr,
  input  logic [31:0]        cmd_wdata,
  input  logic [31:0]        cmd_mask,
  input  logic [LIMIT_W-1:0] poll_limit,
  output logic               rd,
  output logic               wr,
  output logic [31:0]        addr,
  output logic [31:0]        wdata,
  input  logic [31:0]        rdata,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               resp_timeout,
  output logic               busy
);

  state_t state_q, state_d;

  cmd_t push_cmd;
  cmd_t head;
  logic push, pop, full, empty;

  logic [LIMIT_W-1:0] lim_q;
  logic [LIMIT_W-1:0] retry_q;
  logic               poll_active_q;
  logic [LIMIT_W-1:0] limit_eff;
  logic               poll_match;
  logic               poll_continue;

  logic               resp_load;
  logic [31:0]        resp_rdata_d;
  logic               resp_timeout_d;
  logic [31:0]        resp_rdata_q;
  logic               resp_timeout_q;

  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign push_cmd  = '{op: op_t'(cmd_op), addr: cmd_addr, wdata: cmd_wdata, mask: cmd_mask};

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_cmd),
    .full      (full),
    .pop       (pop),
    .pop_data  (head),
    .empty     (empty)
  );

  // The first ISSUE cycle of a poll uses the live limit; later cycles use the latched copy
  assign limit_eff  = poll_active_q ? lim_q : poll_limit;
  assign poll_match = ((rdata & head.mask) == (head.wdata & head.mask));

  assign resp_valid   = (state_q == RESP);
  assign resp_rdata   = resp_rdata_q;
  assign resp_timeout = resp_timeout_q;
  assign busy         = !empty || (state_q != IDLE);

  // State and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      resp_rdata_q   <= '0;
      resp_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (resp_load) begin
        resp_rdata_q   <= resp_rdata_d;
        resp_timeout_q <= resp_timeout_d;
      end
    end
  end

  // Poll retry bookkeeping: latch limit on the first read, count non-matching reads
  always_ff @(posedge clk) begin
    if (reset) begin
      lim_q         <= '0;
      retry_q       <= '0;
      poll_active_q <= 1'b0;
    end else if (poll_continue) begin
      poll_active_q <= 1'b1;
      retry_q       <= retry_q + LIMIT_W'(1);
      if (!poll_active_q) begin
        lim_q <= poll_limit;
      end
    end else if (pop) begin
      poll_active_q <= 1'b0;
      retry_q       <= '0;
    end
  end

  // Next-state, bus strobes and response capture
  always_comb begin
    state_d        = state_q;
    pop            = 1'b0;
    rd             = 1'b0;
    wr             = 1'b0;
    addr           = '0;
    wdata          = '0;
    resp_load      = 1'b0;
    resp_rdata_d   = '0;
    resp_timeout_d = 1'b0;
    poll_continue  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Counting the incoming push lets a new command strobe the very next cycle
        if (!empty || push) begin
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        addr  = head.addr;
        wdata = head.wdata;
        unique case (head.op)
          OP_READ: begin
            rd           = 1'b1;
            pop          = 1'b1;
            resp_load    = 1'b1;
            resp_rdata_d = rdata;
            state_d      = RESP;
          end
          OP_WRITE: begin
            wr        = 1'b1;
            pop       = 1'b1;
            resp_load = 1'b1;
            state_d   = RESP;
          end
          OP_POLL: begin
            rd = 1'b1;
            if (poll_match || (retry_q == limit_eff)) begin
              pop            = 1'b1;
              resp_load      = 1'b1;
              resp_rdata_d   = rdata;
              resp_timeout_d = !poll_match;
              state_d        = RESP;
            end else begin
              poll_continue = 1'b1;
            end
          end
          default: begin
            // Reserved op: no bus activity, answered as a timed-out empty response
            pop            = 1'b1;
            resp_load      = 1'b1;
            resp_timeout_d = 1'b1;
            state_d        = RESP;
          end
        endcase
      end

      RESP: begin
        state_d = empty ? IDLE : ISSUE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_periph_bus_master.sv
// Directed self-checking bench for periph_bus_master with a small peripheral model.
module tb_periph_bus_master;
  import periph_bus_pkg::*;

  localparam int unsigned LIMIT_W = 16;

  logic               clk;
  logic               reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [31:0]        cmd_addr;
  logic [31:0]        cmd_wdata;
  logic [31:0]        cmd_mask;
  logic [LIMIT_W-1:0] poll_limit;
  logic               rd;
  logic               wr;
  logic [31:0]        addr;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               resp_valid;
  logic [31:0]        resp_rdata;
  logic               resp_timeout;
  logic               busy;

  int checks   = 0;
  int failures = 0;

  // Bus activity counters, sampled mid-cycle
  int rd_total   = 0;
  int wr_total   = 0;
  int resp_total = 0;
  int both_total = 0;
  logic [31:0] wr_log [$];

  // Peripheral model controls
  int poll_base = 0;
  int ready_at  = 1000;

  periph_bus_master #(
    .FIFO_DEPTH (4),
    .LIMIT_W    (LIMIT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_mask     (cmd_mask),
    .poll_limit   (poll_limit),
    .rd           (rd),
    .wr           (wr),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_timeout (resp_timeout),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Switches read 0x5A; UART status bit0 becomes 1 once ready_at reads have occurred
  always_comb begin
    rdata = '0;
    if (rd) begin
      if (addr == SWITCH_ADDR) begin
        rdata = 32'h0000_005A;
      end else if (addr == UART_STATUS_ADDR) begin
        rdata = ((rd_total - poll_base) >= ready_at) ? 32'h1 : 32'h0;
      end
    end
  end

  always @(negedge clk) begin
    if (rd) rd_total++;
    if (wr) begin
      wr_total++;
      wr_log.push_back(addr);
    end
    if (rd && wr) both_total++;
    if (resp_valid) resp_total++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Offer one command and return in the cycle after its acceptance edge
  task automatic send(input string tag, input op_t op, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] m);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_mask  = m;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!resp_valid && n < max_cycles) begin
      tick();
      n++;
    end
    check({tag, "_resp_seen"}, 32'(resp_valid), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_b, wr_b, resp_b, log_b, idx, n;
    logic saw_full, rdy;

    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    cmd_mask   = '0;
    poll_limit = '0;

    // Reset state
    repeat (3) tick();
    check("rst_rd", 32'(rd), 32'd0);
    check("rst_wr", 32'(wr), 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_timeout", 32'(resp_timeout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b0;
    tick();

    // Write LED: strobe in N+1 only, response in N+2
    wr_b = wr_total;
    send("wr", OP_WRITE, LED_ADDR, 32'hA5, 32'h0);
    check("wr_n1_wr", 32'(wr), 32'd1);
    check("wr_n1_rd", 32'(rd), 32'd0);
    check("wr_n1_addr", addr, 32'h4000_000C);
    check("wr_n1_wdata", wdata, 32'h0000_00A5);
    check("wr_n1_resp_valid", 32'(resp_valid), 32'd0);
    tick();
    check("wr_n2_wr", 32'(wr), 32'd0);
    check("wr_n2_resp_valid", 32'(resp_valid), 32'd1);
    check("wr_n2_resp_rdata", resp_rdata, 32'd0);
    check("wr_n2_resp_timeout", 32'(resp_timeout), 32'd0);
    check("wr_n2_addr", addr, 32'd0);
    tick();
    check("wr_n3_resp_valid", 32'(resp_valid), 32'd0);
    check("wr_n3_busy", 32'(busy), 32'd0);
    check("wr_strobes", 32'(wr_total - wr_b), 32'd1);

    // Read switches
    rd_b = rd_total;
    send("rdsw", OP_READ, SWITCH_ADDR, 32'h0, 32'h0);
    check("rdsw_n1_rd", 32'(rd), 32'd1);
    check("rdsw_n1_wr", 32'(wr), 32'd0);
    check("rdsw_n1_addr", addr, 32'h4000_0010);
    tick();
    check("rdsw_n2_rd", 32'(rd), 32'd0);
    check("rdsw_n2_resp_valid", 32'(resp_valid), 32'd1);
    check("rdsw_n2_resp_rdata", resp_rdata, 32'h0000_005A);
    check("rdsw_n2_resp_timeout", 32'(resp_timeout), 32'd0);
    tick();
    check("rdsw_strobes", 32'(rd_total - rd_b), 32'd1);

    // Reserved op: no strobe, rdata 0, timeout 1
    rd_b = rd_total;
    wr_b = wr_total;
    send("rsvd", OP_RSVD, LED_ADDR, 32'h77, 32'h0);
    check("rsvd_n1_strobes", {30'd0, rd, wr}, 32'd0);
    tick();
    check("rsvd_resp_valid", 32'(resp_valid), 32'd1);
    check("rsvd_resp_rdata", resp_rdata, 32'd0);
    check("rsvd_resp_timeout", 32'(resp_timeout), 32'd1);
    tick();
    check("rsvd_no_bus", 32'((rd_total - rd_b) + (wr_total - wr_b)), 32'd0);

    // Poll UART status, ready on the 5th read, limit 10
    poll_base  = rd_total;
    ready_at   = 5;
    poll_limit = 16'd10;
    send("pollok", OP_POLL, UART_STATUS_ADDR, 32'h1, 32'h1);
    wait_resp("pollok", 50);
    check("pollok_reads", 32'(rd_total - poll_base), 32'd5);
    check("pollok_rdata", resp_rdata, 32'h1);
    check("pollok_timeout", 32'(resp_timeout), 32'd0);
    tick();

    // Poll never matching (status reads 1, expects 2 under mask 2), limit 3;
    // limit changed after the first read must not matter
    poll_base  = rd_total;
    ready_at   = 0;
    poll_limit = 16'd3;
    send("pollto", OP_POLL, UART_STATUS_ADDR, 32'h2, 32'h2);
    tick();
    poll_limit = 16'd10;
    wait_resp("pollto", 50);
    check("pollto_reads", 32'(rd_total - poll_base), 32'd4);
    check("pollto_rdata", resp_rdata, 32'h1);
    check("pollto_timeout", 32'(resp_timeout), 32'd1);
    tick();

    // Poll limit 0: exactly one read
    poll_base  = rd_total;
    poll_limit = 16'd0;
    send("poll0", OP_POLL, UART_STATUS_ADDR, 32'h0, 32'h1);
    wait_resp("poll0", 20);
    check("poll0_reads", 32'(rd_total - poll_base), 32'd1);
    check("poll0_timeout", 32'(resp_timeout), 32'd1);
    tick();

    // Burst of 8 writes offered back to back
    wr_b     = wr_total;
    resp_b   = resp_total;
    log_b    = wr_log.size();
    idx      = 0;
    saw_full = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = OP_WRITE;
    cmd_addr  = 32'h4000_0100;
    cmd_wdata = 32'h0;
    cmd_mask  = 32'h0;
    for (int cyc = 0; cyc < 100 && idx < 8; cyc++) begin
      if (!cmd_ready && !saw_full) begin
        saw_full = 1'b1;
        check("burst_queued_at_full", 32'(idx - (wr_total - wr_b)), 32'd4);
      end
      rdy = cmd_ready;
      tick();
      if (rdy) begin
        idx++;
        cmd_addr  = 32'h4000_0100 + 32'(idx);
        cmd_wdata = 32'(idx * 17);
      end
    end
    cmd_valid = 1'b0;
    check("burst_saw_full", 32'(saw_full), 32'd1);
    check("burst_accepted", 32'(idx), 32'd8);
    n = 0;
    while ((resp_total - resp_b) < 8 && n < 100) begin
      tick();
      n++;
    end
    tick();
    check("burst_resp_count", 32'(resp_total - resp_b), 32'd8);
    check("burst_wr_count", 32'(wr_total - wr_b), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (log_b + i < wr_log.size()) begin
        check($sformatf("burst_order_%0d", i), wr_log[log_b + i], 32'h4000_0100 + 32'(i));
      end else begin
        check($sformatf("burst_order_%0d_present", i), 32'd0, 32'd1);
      end
    end
    check("never_rd_and_wr", 32'(both_total), 32'd0);

    // Reset in the middle of a poll with two writes queued
    ready_at   = 0;
    poll_limit = 16'd10;
    send("rstmid_poll", OP_POLL, UART_STATUS_ADDR, 32'h2, 32'h2);
    cmd_valid = 1'b1;
    cmd_op    = OP_WRITE;
    cmd_addr  = LED_ADDR;
    cmd_wdata = 32'h11;
    tick();
    cmd_addr  = DIGIT_ADDR;
    cmd_wdata = 32'h22;
    tick();
    cmd_valid = 1'b0;
    check("rstmid_polling_rd", 32'(rd), 32'd1);
    check("rstmid_busy_before", 32'(busy), 32'd1);
    resp_b = resp_total;
    wr_b   = wr_total;
    reset  = 1'b1;
    tick();
    check("rstmid_rd", 32'(rd), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_resp_valid", 32'(resp_valid), 32'd0);
    check("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b0;
    repeat (20) tick();
    check("rstmid_no_resp", 32'(resp_total - resp_b), 32'd0);
    check("rstmid_no_wr", 32'(wr_total - wr_b), 32'd0);
    check("rstmid_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/periph_bus_master.md
PERIPH_BUS_MASTER -- requirements
Module: periph_bus_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter LIMIT_W, default 16, width of the poll retry limit.
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  in  1  command offered.
REQ-006 SHALL have port cmd_ready  out  1  command FIFO can accept.
REQ-007 SHALL have port cmd_op  in  2  operation: 00 read, 01 write, 10 poll, 11 reserved.
REQ-008 SHALL have port cmd_addr  in  32  peripheral address.
REQ-009 SHALL have port cmd_wdata  in  32  write data (write) or expected value (poll).
REQ-010 SHALL have port cmd_mask  in  32  poll compare mask; ignored for read and write.
REQ-011 SHALL have port poll_limit  in  LIMIT_W  maximum poll retries after the first read.
REQ-012 SHALL have port rd  out  1  bus read strobe.
REQ-013 SHALL have port wr  out  1  bus write strobe.
REQ-014 SHALL have port addr  out  32  bus address.
REQ-015 SHALL have port wdata  out  32  bus write data.
REQ-016 SHALL have port rdata  in  32  combinational read data from the peripheral, valid in the same cycle as rd.
REQ-017 SHALL have port resp_valid  out  1  one-cycle response pulse; no backpressure.
REQ-018 SHALL have port resp_rdata  out  32  read or poll data of the last read; 0 for writes.
REQ-019 SHALL have port resp_timeout  out  1  poll ended without a match.
REQ-020 SHALL have port busy  out  1  FIFO non-empty or FSM not IDLE.

Function
REQ-021 SHALL handshake when cmd_valid and cmd_ready are both high at a rising edge, pushing {op, addr, wdata, mask} into the FIFO.
REQ-022 SHALL drive cmd_ready = !full; a push and a pop in the same cycle when not full are both honoured.
REQ-023 SHALL use FSM states IDLE, ISSUE, RESP.
REQ-024 SHALL move IDLE->ISSUE when the FIFO is non-empty; the head entry drives addr/wdata.
REQ-025 SHALL, in ISSUE, assert exactly one of rd (read, poll) or wr (write) for one cycle; rd and wr are never high together.
REQ-026 SHALL, in ISSUE for a read, capture rdata at the end of the cycle, pop the entry and go to RESP.
REQ-027 SHALL, in ISSUE for a write, pop the entry and go to RESP with resp_rdata = 0.
REQ-028 SHALL, for a poll, re-enter ISSUE every cycle until (rdata & mask) == (wdata & mask), then pop and go to RESP with resp_timeout = 0.
REQ-029 SHALL, for a poll, count retries and stop after 1 + poll_limit reads with resp_timeout = 1 and resp_rdata = last read; poll_limit = 0 gives exactly one read.
REQ-030 SHALL latch poll_limit when the poll's first ISSUE cycle begins.
REQ-031 SHALL, in RESP, pulse resp_valid for one cycle, then go to ISSUE if the FIFO is non-empty, else IDLE.
REQ-032 SHALL have latency: acceptance at edge N -> rd/wr high in cycle N+1 -> resp_valid in cycle N+2 (empty FIFO, IDLE FSM); maximum throughput one read or write per 2 cycles.
REQ-033 SHALL hold addr, wdata, rd and wr at 0 outside ISSUE.
REQ-034 SHALL treat reserved op 11 as a write-free no-op: no strobe, resp_valid with resp_rdata = 0 and resp_timeout = 1.

Reset
REQ-035 SHALL, on reset, empty the FIFO, set the FSM to IDLE, and set rd, wr, addr, wdata, resp_valid, resp_rdata, resp_timeout and busy to 0 at the next edge; cmd_ready is 1 after that edge.
REQ-036 SHALL discard any in-flight or queued command on reset mid-operation, with no resp_valid for it.

Structure
REQ-037 SHALL place op encodings, FSM state encoding and the peripheral address map constants (timer 0x40000000-08, LED 0x4000000C, switch 0x40000010, digit 0x40000014, UART 0x40000018-28) in shared package periph_bus_pkg.
REQ-038 SHALL implement the command FIFO as sub-module cmd_fifo (synchronous, FIFO_DEPTH entries, full/empty flags).

Verification
REQ-039 SHALL cover: write 0x4000000C/0xA5 accepted at edge N -> wr=1, addr=0x4000000C, wdata=0xA5 in cycle N+1 only; resp_valid at N+2 with resp_rdata=0.
REQ-040 SHALL cover: read 0x40000010 with model rdata=0x5A -> rd one cycle, resp_rdata=0x5A, resp_timeout=0.
REQ-041 SHALL cover: poll 0x40000020, mask 1, value 1, limit 10, model ready set on the 5th read -> 5 rd cycles, resp_rdata=1, resp_timeout=0.
REQ-042 SHALL cover: poll, limit 3, never matching -> exactly 4 rd cycles, resp_timeout=1.
REQ-043 SHALL cover: 8 commands offered every cycle -> cmd_ready drops when 4 are queued, all 8 are issued in order, 8 resp_valid pulses.
REQ-044 SHALL cover: reset asserted during a poll with 2 commands queued -> rd=0 at the next edge, busy=0, no further resp_valid.
